// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//
// Round-robin scheduler that lets NUM_REQUESTERS clients share one SPI master.
// Each client hands over a single word together with its own SPI mode
// (CPOL/CPHA) and clock divider. The arbiter grants one client at a time,
// loads that client's configuration into the master while the master is
// disabled, runs the transfer and returns the received word to that client.
//
// Optional feature (compile-time macro SPI_ARB_TIMEOUT_EN):
//   defined   -> a watchdog aborts a transfer whose done never arrives
//   undefined -> no watchdog is built and o_rsp_timeout is tied to 0
//
// Ports:
//   i_clock, i_reset         system clock, synchronous active-high reset
//   i_req_valid / o_req_ready per-client request and one-hot accept strobe
//   i_req_data               client TX words, client k at [k*W +: W]
//   i_req_cpol / i_req_cpha  per-client SPI mode
//   i_req_divider            per-client divider, client k at [k*D +: D]
//   o_rsp_valid              one-cycle response pulse to the owning client
//   o_rsp_data               received word, valid with o_rsp_valid
//   o_rsp_timeout            response was produced by the watchdog
//   o_spi_*                  enable, mode, divider and TX data to the master
//   i_spi_data_out           received word from the master
//   i_spi_done               transfer complete strobe from the master
//   o_spi_cs_sel             one-hot device select (gated externally with cs_n)
//   o_busy                   arbiter is not idle
module spi_master_arbiter #(
  parameter int NUM_REQUESTERS          = 4,
  parameter int SPI_CLOCK_DIVIDER_WIDTH = 4,
  parameter int SPI_DATA_WIDTH          = 8,
  parameter int GAP_CYCLES              = 2,
  parameter int TIMEOUT_WIDTH           = 16
) (
  input  logic                                              i_clock,
  input  logic                                              i_reset,
  input  logic [NUM_REQUESTERS-1:0]                         i_req_valid,
  output logic [NUM_REQUESTERS-1:0]                         o_req_ready,
  input  logic [NUM_REQUESTERS*SPI_DATA_WIDTH-1:0]          i_req_data,
  input  logic [NUM_REQUESTERS-1:0]                         i_req_cpol,
  input  logic [NUM_REQUESTERS-1:0]                         i_req_cpha,
  input  logic [NUM_REQUESTERS*SPI_CLOCK_DIVIDER_WIDTH-1:0] i_req_divider,
  output logic [NUM_REQUESTERS-1:0]                         o_rsp_valid,
  output logic [SPI_DATA_WIDTH-1:0]                         o_rsp_data,
  output logic                                              o_rsp_timeout,
  output logic                                              o_spi_enable,
  output logic                                              o_spi_clock_polarity,
  output logic                                              o_spi_clock_phase,
  output logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]                o_spi_clock_divider,
  output logic [SPI_DATA_WIDTH-1:0]                         o_spi_data_in,
  input  logic [SPI_DATA_WIDTH-1:0]                         i_spi_data_out,
  input  logic                                              i_spi_done,
  output logic [NUM_REQUESTERS-1:0]                         o_spi_cs_sel,
  output logic                                              o_busy
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_GAP
  } state_t;

  state_t                               state_q, state_d;
  logic [PTR_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                     grant_q, grant_d;
  logic [SPI_DATA_WIDTH-1:0]            data_q, data_d;
  logic                                 cpol_q, cpol_d;
  logic                                 cpha_q, cpha_d;
  logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]   div_q, div_d;
  logic [NUM_REQUESTERS-1:0]            cs_sel_q, cs_sel_d;
  logic [SPI_DATA_WIDTH-1:0]            rx_q, rx_d;
  logic [GAP_W-1:0]                     gap_cnt_q, gap_cnt_d;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0]             wdog_q, wdog_d;
  logic [TIMEOUT_WIDTH-1:0]             wdog_inc;
  logic                                 wdog_expire;
  logic                                 tout_q, tout_d;
`else
  logic                                 unused_timeout_width;
  assign unused_timeout_width = (TIMEOUT_WIDTH != 0);
`endif

  logic                                 arb_found;
  logic [PTR_W-1:0]                     arb_idx;
  logic [SPI_DATA_WIDTH-1:0]            sel_data;
  logic                                 sel_cpol;
  logic                                 sel_cpha;
  logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]   sel_div;
  logic                                 rsp_fire;

  function automatic logic [NUM_REQUESTERS-1:0] one_hot(input logic [PTR_W-1:0] idx);
    one_hot = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search: first valid client at or above rr_ptr, wrapping.
  always_comb begin
    int cand_int;
    logic [PTR_W-1:0] cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_int  = 0;
    cand      = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand_int = int'(rr_ptr_q) + i;
      if (cand_int >= NUM_REQUESTERS) begin
        cand_int = cand_int - NUM_REQUESTERS;
      end
      cand = PTR_W'(cand_int);
      if (!arb_found && i_req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Pick the granted client's fields out of the packed request buses.
  always_comb begin
    sel_data = '0;
    sel_cpol = 1'b0;
    sel_cpha = 1'b0;
    sel_div  = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (arb_idx == PTR_W'(k)) begin
        sel_data = i_req_data[k*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
        sel_cpol = i_req_cpol[k];
        sel_cpha = i_req_cpha[k];
        sel_div  = i_req_divider[k*SPI_CLOCK_DIVIDER_WIDTH +: SPI_CLOCK_DIVIDER_WIDTH];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Expire on the XFER cycle whose increment would reach the all-ones count,
  // so the master is enabled for exactly 2^TIMEOUT_WIDTH-1 cycles.
  assign wdog_inc    = wdog_q + TIMEOUT_WIDTH'(1);
  assign wdog_expire = &wdog_inc;
`endif

  // Next-state logic. Transfer registers only load on accept in IDLE, so the
  // master's configuration can only change while its enable is low.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    cs_sel_d  = cs_sel_q;
    rx_d      = rx_q;
    gap_cnt_d = gap_cnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
    wdog_d    = wdog_q;
    tout_d    = tout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d  = arb_idx;
          data_d   = sel_data;
          cpol_d   = sel_cpol;
          cpha_d   = sel_cpha;
          // A divider of zero would stall the master, so it runs at 1.
          div_d    = (sel_div == '0) ? SPI_CLOCK_DIVIDER_WIDTH'(1) : sel_div;
          cs_sel_d = one_hot(arb_idx);
          rr_ptr_d = (arb_idx == PTR_W'(NUM_REQUESTERS - 1)) ? '0 : arb_idx + PTR_W'(1);
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        gap_cnt_d = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        wdog_d    = '0;
`endif
        state_d   = ST_XFER;
      end
      ST_XFER: begin
        // Done wins over a watchdog expiry in the same cycle.
        if (i_spi_done) begin
          rx_d    = i_spi_data_out;
`ifdef SPI_ARB_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
          state_d = ST_GAP;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (wdog_expire) begin
          rx_d    = '0;
          tout_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          wdog_d  = wdog_inc;
`endif
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          cs_sel_d  = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; an in-flight transfer is dropped.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      cs_sel_q  <= '0;
      rx_q      <= '0;
      gap_cnt_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_q    <= '0;
      tout_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      cs_sel_q  <= cs_sel_d;
      rx_q      <= rx_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_q    <= wdog_d;
      tout_q    <= tout_d;
`endif
    end
  end

  // The response pulse is the first GAP cycle.
  assign rsp_fire = (state_q == ST_GAP) && (gap_cnt_q == '0);

  assign o_req_ready          = (state_q == ST_IDLE && arb_found) ? one_hot(arb_idx) : '0;
  assign o_rsp_valid          = rsp_fire ? one_hot(grant_q) : '0;
  assign o_rsp_data           = rsp_fire ? rx_q : '0;
`ifdef SPI_ARB_TIMEOUT_EN
  assign o_rsp_timeout        = rsp_fire & tout_q;
`else
  assign o_rsp_timeout        = 1'b0;
`endif
  assign o_spi_enable         = (state_q == ST_XFER);
  assign o_spi_clock_polarity = cpol_q;
  assign o_spi_clock_phase    = cpha_q;
  assign o_spi_clock_divider  = div_q;
  assign o_spi_data_in        = data_q;
  assign o_spi_cs_sel         = cs_sel_q;
  assign o_busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter (4 clients, 4-bit divider, 8-bit
// words, 2 gap cycles, 4-bit watchdog). Inputs change and outputs are
// sampled just after the falling clock edge.
module tb_spi_master_arbiter;

  localparam int N   = 4;
  localparam int D   = 4;
  localparam int W   = 8;
  localparam int GAP = 2;
  localparam int TW  = 4;

  logic             i_clock = 1'b0;
  logic             i_reset;
  logic [N-1:0]     i_req_valid;
  logic [N-1:0]     o_req_ready;
  logic [N*W-1:0]   i_req_data;
  logic [N-1:0]     i_req_cpol;
  logic [N-1:0]     i_req_cpha;
  logic [N*D-1:0]   i_req_divider;
  logic [N-1:0]     o_rsp_valid;
  logic [W-1:0]     o_rsp_data;
  logic             o_rsp_timeout;
  logic             o_spi_enable;
  logic             o_spi_clock_polarity;
  logic             o_spi_clock_phase;
  logic [D-1:0]     o_spi_clock_divider;
  logic [W-1:0]     o_spi_data_in;
  logic [W-1:0]     i_spi_data_out;
  logic             i_spi_done;
  logic [N-1:0]     o_spi_cs_sel;
  logic             o_busy;

  int total = 0;
  int bad   = 0;

  spi_master_arbiter #(
    .NUM_REQUESTERS(N),
    .SPI_CLOCK_DIVIDER_WIDTH(D),
    .SPI_DATA_WIDTH(W),
    .GAP_CYCLES(GAP),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_data(i_req_data),
    .i_req_cpol(i_req_cpol),
    .i_req_cpha(i_req_cpha),
    .i_req_divider(i_req_divider),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data),
    .o_rsp_timeout(o_rsp_timeout),
    .o_spi_enable(o_spi_enable),
    .o_spi_clock_polarity(o_spi_clock_polarity),
    .o_spi_clock_phase(o_spi_clock_phase),
    .o_spi_clock_divider(o_spi_clock_divider),
    .o_spi_data_in(o_spi_data_in),
    .i_spi_data_out(i_spi_data_out),
    .i_spi_done(i_spi_done),
    .o_spi_cs_sel(o_spi_cs_sel),
    .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request from one client with its own word, mode and divider.
  task automatic applyStimulus(input int client, input logic [7:0] data,
                               input logic pol, input logic pha, input logic [3:0] div);
    i_req_valid   = i_req_valid | (N'(1) << client);
    i_req_data    = (i_req_data & ~(32'hFF << (client * W))) | (32'(data) << (client * W));
    i_req_cpol    = (i_req_cpol & ~(N'(1) << client)) | (N'(pol) << client);
    i_req_cpha    = (i_req_cpha & ~(N'(1) << client)) | (N'(pha) << client);
    i_req_divider = (i_req_divider & ~(16'hF << (client * D))) | (16'(div) << (client * D));
  endtask

  task automatic nextCycle();
    @(negedge i_clock);
    #1;
  endtask

  task automatic clearInputs();
    i_req_valid    = '0;
    i_req_data     = '0;
    i_req_cpol     = '0;
    i_req_cpha     = '0;
    i_req_divider  = '0;
    i_spi_data_out = '0;
    i_spi_done     = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    i_reset = 1'b1;
    nextCycle();
    nextCycle();
    i_reset = 1'b0;
  endtask

  // Wait (bounded) until the arbiter shows any grant.
  task automatic waitReady(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_req_ready != '0) break;
      nextCycle();
    end
  endtask

  // Wait (bounded) for enable, finish the transfer with one done pulse and
  // wait for the arbiter to go idle.
  task automatic finishXfer(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (o_spi_enable) break;
      nextCycle();
    end
    checkOutput({tag, "_en"}, 32'(o_spi_enable), 32'd1);
    i_spi_done     = 1'b1;
    i_spi_data_out = 8'h5A;
    nextCycle();
    i_spi_done     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!o_busy) break;
      nextCycle();
    end
    checkOutput({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  // One complete transfer for a single client, checking every phase.
  task automatic serveOne(input string tag, input int client, input logic [7:0] tx,
                          input logic pol, input logic pha, input logic [3:0] div,
                          input logic [7:0] rx, input int nx);
    logic [3:0] expDiv;
    logic [3:0] expSel;
    expDiv = (div == 4'd0) ? 4'd1 : div;
    expSel = 4'b0001 << client;
    applyStimulus(client, tx, pol, pha, div);
    #1;
    waitReady(20);
    checkOutput({tag, "_ready"}, 32'(o_req_ready), 32'(expSel));
    nextCycle();
    // Withdraw and scramble the request: the accepted copy must not change.
    i_req_valid   = '0;
    i_req_data    = ~i_req_data;
    i_req_cpol    = ~i_req_cpol;
    i_req_cpha    = ~i_req_cpha;
    i_req_divider = ~i_req_divider;
    #1;
    checkOutput({tag, "_setupEn"}, 32'(o_spi_enable), 32'd0);
    checkOutput({tag, "_setupCs"}, 32'(o_spi_cs_sel), 32'(expSel));
    checkOutput({tag, "_setupPol"}, 32'(o_spi_clock_polarity), 32'(pol));
    checkOutput({tag, "_setupPha"}, 32'(o_spi_clock_phase), 32'(pha));
    checkOutput({tag, "_setupDiv"}, 32'(o_spi_clock_divider), 32'(expDiv));
    checkOutput({tag, "_setupData"}, 32'(o_spi_data_in), 32'(tx));
    checkOutput({tag, "_setupReady"}, 32'(o_req_ready), 32'd0);
    for (int k = 0; k < nx; k++) begin
      nextCycle();
      checkOutput({tag, "_xferEn"}, 32'(o_spi_enable), 32'd1);
      checkOutput({tag, "_xferPol"}, 32'(o_spi_clock_polarity), 32'(pol));
      checkOutput({tag, "_xferPha"}, 32'(o_spi_clock_phase), 32'(pha));
      checkOutput({tag, "_xferDiv"}, 32'(o_spi_clock_divider), 32'(expDiv));
      checkOutput({tag, "_xferCs"}, 32'(o_spi_cs_sel), 32'(expSel));
      checkOutput({tag, "_xferRsp"}, 32'(o_rsp_valid), 32'd0);
    end
    i_spi_done     = 1'b1;
    i_spi_data_out = rx;
    nextCycle();
    i_spi_done     = 1'b0;
    i_spi_data_out = 8'h00;
    checkOutput({tag, "_gapEn"}, 32'(o_spi_enable), 32'd0);
    checkOutput({tag, "_rspValid"}, 32'(o_rsp_valid), 32'(expSel));
    checkOutput({tag, "_rspData"}, 32'(o_rsp_data), 32'(rx));
    checkOutput({tag, "_rspTout"}, 32'(o_rsp_timeout), 32'd0);
    checkOutput({tag, "_gapCs"}, 32'(o_spi_cs_sel), 32'(expSel));
    nextCycle();
    checkOutput({tag, "_gap2Rsp"}, 32'(o_rsp_valid), 32'd0);
    checkOutput({tag, "_gap2Cs"}, 32'(o_spi_cs_sel), 32'(expSel));
    checkOutput({tag, "_gap2Busy"}, 32'(o_busy), 32'd1);
    nextCycle();
    checkOutput({tag, "_idleBusy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_idleCs"}, 32'(o_spi_cs_sel), 32'd0);
  endtask

  initial begin
    int gapCount;
    int enCount;
    int grantSeq [5] = '{0, 1, 2, 3, 0};

    clearInputs();
    i_reset = 1'b1;
    doReset();

    // Reset state.
    checkOutput("rstEn", 32'(o_spi_enable), 32'd0);
    checkOutput("rstCs", 32'(o_spi_cs_sel), 32'd0);
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    checkOutput("rstRsp", 32'(o_rsp_valid), 32'd0);
    checkOutput("rstRspData", 32'(o_rsp_data), 32'd0);
    checkOutput("rstTout", 32'(o_rsp_timeout), 32'd0);
    checkOutput("rstDiv", 32'(o_spi_clock_divider), 32'd0);
    checkOutput("rstPol", 32'(o_spi_clock_polarity), 32'd0);
    checkOutput("rstPha", 32'(o_spi_clock_phase), 32'd0);
    checkOutput("rstData", 32'(o_spi_data_in), 32'd0);
    checkOutput("rstReady", 32'(o_req_ready), 32'd0);

    // Single client 1 transfer.
    serveOne("c1", 1, 8'hA5, 1'b1, 1'b0, 4'd3, 8'h3C, 3);
    // Mode changes between clients; client 3 also exercises divider 0.
    serveOne("c2", 2, 8'h96, 1'b0, 1'b1, 4'd5, 8'h11, 2);
    serveOne("c3", 3, 8'h4B, 1'b1, 1'b1, 4'd0, 8'hE7, 4);

    // Round robin from reset with every client requesting continuously.
    doReset();
    for (int k = 0; k < N; k++) begin
      applyStimulus(k, 8'h10 + 8'(k), 1'b0, 1'b0, 4'(k + 1));
    end
    #1;
    for (int g = 0; g < 5; g++) begin
      if (g == 0) begin
        waitReady(20);
      end else begin
        gapCount = 0;
        for (int i = 0; i < 20; i++) begin
          nextCycle();
          gapCount++;
          if (gapCount == 1) begin
            i_spi_done = 1'b0;
            checkOutput("rrRsp", 32'(o_rsp_valid), 32'(4'b0001 << grantSeq[g-1]));
            checkOutput("rrRspData", 32'(o_rsp_data), 32'(8'hC0 + 8'(g - 1)));
          end
          if (o_req_ready != '0) break;
        end
        checkOutput("rrGap", 32'(gapCount), 32'(GAP + 1));
      end
      checkOutput("rrGrant", 32'(o_req_ready), 32'(4'b0001 << grantSeq[g]));
      nextCycle();
      checkOutput("rrSetupData", 32'(o_spi_data_in), 32'(8'h10 + 8'(grantSeq[g])));
      checkOutput("rrSetupEn", 32'(o_spi_enable), 32'd0);
      nextCycle();
      checkOutput("rrXferEn", 32'(o_spi_enable), 32'd1);
      nextCycle();
      i_spi_done     = 1'b1;
      i_spi_data_out = 8'hC0 + 8'(g);
    end
    i_req_valid = '0;
    nextCycle();
    i_spi_done = 1'b0;
    checkOutput("rrLastRsp", 32'(o_rsp_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (!o_busy) break;
      nextCycle();
    end
    checkOutput("rrIdle", 32'(o_busy), 32'd0);

    // Reset in the middle of a transfer.
    applyStimulus(2, 8'h77, 1'b1, 1'b1, 4'd4);
    #1;
    waitReady(20);
    checkOutput("midReady", 32'(o_req_ready), 32'b0100);
    nextCycle();
    i_req_valid = '0;
    nextCycle();
    checkOutput("midXferEn", 32'(o_spi_enable), 32'd1);
    i_reset = 1'b1;
    nextCycle();
    checkOutput("midEn", 32'(o_spi_enable), 32'd0);
    checkOutput("midCs", 32'(o_spi_cs_sel), 32'd0);
    checkOutput("midBusy", 32'(o_busy), 32'd0);
    checkOutput("midRsp", 32'(o_rsp_valid), 32'd0);
    i_reset = 1'b0;
    i_req_valid = 4'b1111;
    #1;
    checkOutput("midFirstGrant", 32'(o_req_ready), 32'b0001);
    nextCycle();
    i_req_valid = '0;
    checkOutput("midAfterRsp", 32'(o_rsp_valid), 32'd0);
    checkOutput("midAfterCs", 32'(o_spi_cs_sel), 32'b0001);
    finishXfer("midDrain");

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog abort with done never arriving.
    doReset();
    applyStimulus(0, 8'h33, 1'b0, 1'b0, 4'd2);
    #1;
    waitReady(20);
    checkOutput("toReady", 32'(o_req_ready), 32'b0001);
    nextCycle();
    i_req_valid = '0;
    enCount = 0;
    for (int i = 0; i < 100; i++) begin
      nextCycle();
      if (o_spi_enable) enCount++;
      else if (enCount > 0) break;
    end
    checkOutput("toCycles", 32'(enCount), 32'd15);
    checkOutput("toRsp", 32'(o_rsp_valid), 32'b0001);
    checkOutput("toFlag", 32'(o_rsp_timeout), 32'd1);
    checkOutput("toData", 32'(o_rsp_data), 32'd0);
    nextCycle();
    nextCycle();
    checkOutput("toIdle", 32'(o_busy), 32'd0);
`else
    enCount = 0;
    checkOutput("noToFlag", 32'(o_rsp_timeout) + 32'(enCount), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin scheduler that shares one `spi_master_top` instance between `NUM_REQUESTERS` independent clients. Each client submits one-word transfers that carry their own SPI mode (CPOL/CPHA) and clock divider. The arbiter sequences the master's enable, per-transfer configuration and chip-select routing, then returns the received word to the originating client. It sits between the register/DMA clients and the SPI master.

## Interface
- `NUM_REQUESTERS`, 4: number of clients, 2..8.
- `SPI_CLOCK_DIVIDER_WIDTH`, 4: width of the divider field.
- `SPI_DATA_WIDTH`, 8: transfer word width.
- `GAP_CYCLES`, 2: idle cycles with enable low between transfers, ≥1.
- `TIMEOUT_WIDTH`, 16: width of the transfer watchdog counter.

Ports:
- `i_clock` in 1: system clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req_valid` in N: per-client request.
- `o_req_ready` in/out: out N, one-hot grant/accept strobe.
- `i_req_data` in N*W: client TX words, client k at `[k*W +: W]`.
- `i_req_cpol`, `i_req_cpha` in N: per-client mode.
- `i_req_divider` in N*D: per-client divider.
- `o_rsp_valid` out N: one-cycle response pulse to the owning client.
- `o_rsp_data` out W: received word, valid with `o_rsp_valid`.
- `o_rsp_timeout` out 1: response was aborted by the watchdog.
- `o_spi_enable`, `o_spi_clock_polarity`, `o_spi_clock_phase` out 1: to master.
- `o_spi_clock_divider` out D, `o_spi_data_in` out W: to master.
- `i_spi_data_out` in W, `i_spi_done` in 1: from master.
- `o_spi_cs_sel` out N: one-hot device select, gated externally with master `cs_n`.
- `o_busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, SETUP, XFER, GAP.
- **IDLE**
  - `o_req_ready` is driven combinationally with a one-hot bit for the first requester with valid set, searching upward from `rr_ptr` with wrap.
  - On valid&ready, the block captures data, cpol, cpha and divider into transfer registers.
  - On the same accept, `rr_ptr` ← granted+1 mod N, and the FSM moves to SETUP.
  - `o_req_ready` is 0 in every other state.
- **SETUP** (1 cycle)
  - Config, data and `o_spi_cs_sel` are driven from the transfer registers; `o_spi_enable`=0.
  - Next state is XFER.
- **XFER**
  - `o_spi_enable`=1; config is held stable.
  - On `i_spi_done`=1, the block captures `i_spi_data_out` and goes to GAP with a success response.
- **GAP**
  - `o_spi_enable`=0; `o_spi_cs_sel` is held.
  - A gap counter runs `GAP_CYCLES` cycles, then `o_spi_cs_sel` ← 0 and the FSM returns to IDLE.
- **Response**: on the GAP entry cycle, the block pulses `o_rsp_valid[granted]` for 1 cycle with `o_rsp_data` and `o_rsp_timeout`.
- **Divider 0**: a divider of 0 is forwarded as 1.
- **Request changes**: once accepted, a request is unaffected by later changes to its inputs. A client deasserting valid in IDLE before grant is simply not served.
- **Simultaneous events**: a done and a watchdog expiry in the same cycle resolve as done, with timeout=0.

## Timing
- **Reset values**:
  - All outputs are 0: `o_spi_enable`, mode, divider, data, `o_spi_cs_sel`, `o_rsp_*`, `o_busy`.
  - State is IDLE, `rr_ptr`=0 and the counters are 0.
- **Latency**: accept at cycle T → enable rises at T+2. Done at cycle D → enable low and `o_rsp_valid` at D+1.
- **Back-to-back**: with continuous requests, the next accept is possible at D+1+`GAP_CYCLES`.
- **Reset mid-operation**: reset forces IDLE on the next edge. No response pulse is generated, and the aborted request is lost.

## Configuration
- **`SPI_ARB_TIMEOUT_EN` defined**
  - A watchdog counts cycles in XFER from 0.
  - When the count reaches 2^`TIMEOUT_WIDTH`−1 without done, the FSM moves to GAP with `o_rsp_timeout`=1 and `o_rsp_data`=0.
- **`SPI_ARB_TIMEOUT_EN` undefined**
  - No watchdog logic is built; XFER waits indefinitely for done.
  - `o_rsp_timeout` is tied to 0.

## Test plan
- Client 1 alone, data 0xA5, cpol=1, cpha=0, divider 3, slave returns 0x3C → enable high 2 cycles after accept, `o_rsp_valid[1]` pulse with 0x3C, `o_spi_cs_sel`=0b0010.
- All 4 clients valid continuously from reset → grants in order 0,1,2,3,0. Each transfer is separated by exactly 2 enable-low gap cycles.
- Client 2 with mode (0,1) then client 3 with (1,1) → master mode and divider change only while `o_spi_enable`=0. Both are stable throughout XFER.
- Timeout build, `TIMEOUT_WIDTH`=4, `i_spi_done` tied 0 → abort after 15 XFER cycles, `o_rsp_timeout`=1, data 0, FSM returns to IDLE.
- Reset asserted in XFER → next cycle enable=0, cs_sel=0, `o_busy`=0, no `o_rsp_valid`. The first grant after reset goes to client 0.
- Request with divider 0 → `o_spi_clock_divider`=1 during SETUP/XFER.
